// File: rtl/cla_nibble_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cla_nibble_seq_ctrl
//  Description : Multi-cycle add/subtract sequencer. A single 4-bit
//                carry-lookahead slice is reused across the WIDTH-bit operands,
//                one nibble per clock, LSB nibble first, with the slice carry
//                held in a register between nibbles.
//  Revision    : 1.0  initial release
// ============================================================================
module cla_nibble_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operand registers shift right one nibble per step so the slice always
    // reads the low nibble; B is stored pre-inverted for subtraction.
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;
    // Completed nibbles collect here (newest at the top) until the last step.
    logic [WIDTH-5:0]   shadow;

    logic               accept;
    logic               step;
    logic               last;

    logic [3:0]         x;
    logic [3:0]         y;
    logic [3:0]         g;
    logic [3:0]         p;
    wire  [3:0]         c;
    logic [3:0]         nib_sum;

    // Carry-lookahead slice on the current nibble
    assign x = a_reg[3:0];
    assign y = b_reg[3:0];
    assign g = x & y;
    assign p = x | y;
    assign c[0] = g[0] | (p[0] & carry_reg);

    for (genvar k = 1; k < 4; k++) begin : g_carry
        assign c[k] = g[k] | (p[k] & c[k-1]);
    end

    assign nib_sum = x ^ y ^ {c[2:0], carry_reg};
    assign last    = (idx == IDX_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture and per-nibble datapath advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            shadow    <= '0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub ? ~cin : cin;
            idx       <= '0;
        end else if (step) begin
            a_reg     <= a_reg >> 4;
            b_reg     <= b_reg >> 4;
            carry_reg <= c[3];
            shadow    <= (WIDTH-4)'({nib_sum, shadow} >> 4);
            idx       <= last ? '0 : idx + 1'b1;
        end
    end

    // Result registers: updated only when the final nibble completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (step && last) begin
            sum  <= {nib_sum, shadow};
            cout <= c[3];
            ovf  <= c[3] ^ c[2];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_nibble_seq_ctrl
//  Description : Self-checking bench for cla_nibble_seq_ctrl (WIDTH=16):
//                directed vector table, reset corner case and random ops
//                compared against a plain-arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cla_nibble_seq_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] exp_hold;
    logic             exp_hold_c;
    logic             exp_hold_o;

    cla_nibble_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          sub;
        bit          cin;
        logic [15:0] a;
        logic [15:0] b;
        bit          noise;
        logic [15:0] exp_sum;
        bit          exp_cout;
        bit          exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, signed range test for overflow,
    // unsigned carry/no-borrow test for cout.
    function automatic void model(input bit s, input bit ci,
                                  input logic [15:0] av, input logic [15:0] bv,
                                  output logic [15:0] rs, output bit rc, output bit ro);
        int ua;
        int ub;
        int sa;
        int sb;
        int ur;
        int sr;
        ua = int'(av);
        ub = int'(bv);
        sa = int'($signed(av));
        sb = int'($signed(bv));
        if (!s) begin
            ur = ua + ub + int'(ci);
            sr = sa + sb + int'(ci);
            rc = (ur > 65535);
        end else begin
            ur = ua - ub - int'(ci);
            sr = sa - sb - int'(ci);
            rc = (ua >= ub + int'(ci));
        end
        rs = ur[15:0];
        ro = (sr > 32767) || (sr < -32768);
    endfunction

    // Runs one operation from a negedge with ready=1. Inputs are scrambled
    // every cycle after acceptance; with noise, start is also pulsed while busy.
    task automatic do_op(input string name, input bit s, input bit ci,
                         input logic [15:0] av, input logic [15:0] bv, input bit noise,
                         input logic [15:0] es, input bit ec, input bit eo);
        int lat;
        chk({name, " ready_before"}, 32'(ready), 32'd1);
        sub   = s;
        cin   = ci;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 20) begin
            chk({name, " hold_sum"}, 32'(sum), 32'(exp_hold));
            a   = 16'($urandom);
            b   = 16'($urandom);
            sub = 1'($urandom);
            cin = 1'($urandom);
            if (noise) start = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'd4);
        chk({name, " ready_in_done"}, 32'(ready), 32'd0);
        chk({name, " sum"}, 32'(sum), 32'(es));
        chk({name, " cout"}, 32'(cout), 32'(ec));
        chk({name, " ovf"}, 32'(ovf), 32'(eo));
        if (noise) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, " ready_after"}, 32'(ready), 32'd1);
        chk({name, " done_once"}, 32'(done), 32'd0);
        chk({name, " sum_kept"}, 32'(sum), 32'(es));
        exp_hold   = es;
        exp_hold_c = ec;
        exp_hold_o = eo;
    endtask

    vec_t vecs[8];

    initial begin
        logic [15:0] rs;
        bit          rc;
        bit          ro;
        int          lat;

        vecs[0] = '{"add_1234_4321", 1'b0, 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{"add_ffff_1",    1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"add_7fff_1",    1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{"sub_5_7",       1'b1, 1'b0, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{"sub_8000_1",    1'b1, 1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{"sub_cin_0_0",   1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[6] = '{"add_cin_ffff",  1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{"add_8000_8000", 1'b0, 1'b0, 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        exp_hold   = '0;
        exp_hold_c = 1'b0;
        exp_hold_o = 1'b0;

        @(negedge clk);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset done",  32'(done),  32'd0);
        chk("reset sum",   32'(sum),   32'd0);
        chk("reset cout",  32'(cout),  32'd0);
        chk("reset ovf",   32'(ovf),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed table, issued back-to-back
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].name, vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b,
                  vecs[i].noise, vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        // Reset after E2 aborts the operation with no done pulse
        sub   = 1'b0;
        cin   = 1'b0;
        a     = 16'h1111;
        b     = 16'h2222;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset ready", 32'(ready), 32'd1);
        chk("midreset done",  32'(done),  32'd0);
        chk("midreset sum",   32'(sum),   32'd0);
        chk("midreset cout",  32'(cout),  32'd0);
        chk("midreset ovf",   32'(ovf),   32'd0);
        @(negedge clk);
        chk("midreset done_held", 32'(done), 32'd0);
        rst = 1'b0;
        exp_hold   = '0;
        exp_hold_c = 1'b0;
        exp_hold_o = 1'b0;
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) lat++;
        end
        chk("midreset no_done_pulse", 32'(lat), 32'd0);
        do_op("after_reset_0f0f_00f1", 1'b0, 1'b0, 16'h0F0F, 16'h00F1, 1'b0,
              16'h1000, 1'b0, 1'b0);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            bit          rsub;
            bit          rcin;
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rsub = 1'($urandom);
            rcin = 1'($urandom);
            if (i % 8 == 0) ra = 16'hFFFF;
            if (i % 8 == 1) rb = 16'h8000;
            model(rsub, rcin, ra, rb, rs, rc, ro);
            do_op("random", rsub, rcin, ra, rb, 1'($urandom), rs, rc, ro);
            if (($urandom % 4) == 0) begin
                @(negedge clk);
                chk("idle done", 32'(done), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
